// File: rtl/vga_sync.sv
// VGA raster timing: pixel-rate enable, x/y raster counters, blanking and
// active-low sync pulses, plus line/frame wrap ticks for downstream graphics.
module vga_sync #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_DISPLAY + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             x_wrap;
    logic             y_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div    <= '0;
            p_tick <= 1'b0;
        end else begin
            p_tick <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    assign x_wrap = (x == X_LAST);
    assign y_wrap = (y == Y_LAST);

    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (p_tick) begin
            if (x_wrap) begin
                x_nxt = '0;
                y_nxt = y_wrap ? '0 : y + 10'd1;
            end else begin
                x_nxt = x + 10'd1;
            end
        end
    end

    // Syncs are decoded from the next counts so they change together with x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            x     <= x_nxt;
            y     <= y_nxt;
            hsync <= !((x_nxt >= 10'(HS_START)) && (x_nxt <= 10'(HS_END)));
            vsync <= !((y_nxt >= 10'(VS_START)) && (y_nxt <= 10'(VS_END)));
        end
    end

    assign video_on   = (x < 10'(H_DISPLAY)) && (y < 10'(V_DISPLAY));
    assign line_tick  = p_tick && x_wrap;
    assign frame_tick = line_tick && y_wrap;

endmodule

// File: tb/tb_vga_sync.sv
// Randomized-reset bench for vga_sync: three instances (full VGA, and a small
// raster at two dividers) compared every clk against an arithmetic raster model.
module tb_vga_sync;

    localparam int HD = 20, HF = 2, HS = 3, HB = 4;
    localparam int VD = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic       a_pt, a_vo, a_hs, a_vs, a_lt, a_ft;
    logic       b_pt, b_vo, b_hs, b_vs, b_lt, b_ft;
    logic       c_pt, c_vo, c_hs, c_vs, c_lt, c_ft;
    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;

    int total = 0;
    int bad   = 0;
    int na = 0, nb = 0, nc = 0;

    int a_hs_lo = 0, a_lines = 0, a_blank = 0;
    int b_von = 0, b_frames = 0, b_vs_lo = 0, b_row_hit = 0;
    int c_frames = 0, c_ticks = 0;

    vga_sync dut_a (
        .clk(clk), .reset(rst_a), .p_tick(a_pt), .x(a_x), .y(a_y),
        .video_on(a_vo), .hsync(a_hs), .vsync(a_vs),
        .line_tick(a_lt), .frame_tick(a_ft)
    );

    vga_sync #(
        .CLK_DIV(3), .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut_b (
        .clk(clk), .reset(rst_b), .p_tick(b_pt), .x(b_x), .y(b_y),
        .video_on(b_vo), .hsync(b_hs), .vsync(b_vs),
        .line_tick(b_lt), .frame_tick(b_ft)
    );

    vga_sync #(
        .CLK_DIV(1), .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut_c (
        .clk(clk), .reset(rst_c), .p_tick(c_pt), .x(c_x), .y(c_y),
        .video_on(c_vo), .hsync(c_hs), .vsync(c_vs),
        .line_tick(c_lt), .frame_tick(c_ft)
    );

    // Clocks elapsed since reset release; zero while reset is held.
    always @(posedge clk) begin
        na <= rst_a ? 0 : na + 1;
        nb <= rst_b ? 0 : nb + 1;
        nc <= rst_c ? 0 : nc + 1;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pixel k is the number of pixel enables consumed; the raster position
    // is simply k modulo the frame size, unrolled into column and row.
    task automatic check_dut(input string nm, input int n, input int d,
                             input int hd, input int hf, input int hs, input int hb,
                             input int vd, input int vf, input int vs, input int vb,
                             input logic pt, input logic [9:0] xo, input logic [9:0] yo,
                             input logic vo, input logic hso, input logic vso,
                             input logic lt, input logic ft);
        int ht, vt, k, p, ex, ey;
        bit ept, elt;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        k   = (n == 0) ? 0 : (n - 1) / d;
        p   = k % (ht * vt);
        ex  = p % ht;
        ey  = p / ht;
        ept = (n > 0) && (n % d == 0);
        elt = ept && (ex == ht - 1);
        check_val({nm, ".p_tick"},   int'(pt),  int'(ept));
        check_val({nm, ".x"},        int'(xo),  ex);
        check_val({nm, ".y"},        int'(yo),  ey);
        check_val({nm, ".video_on"}, int'(vo),  int'(ex < hd && ey < vd));
        check_val({nm, ".hsync"},    int'(hso), int'(!(ex >= hd + hf && ex < hd + hf + hs)));
        check_val({nm, ".vsync"},    int'(vso), int'(!(ey >= vd + vf && ey < vd + vf + vs)));
        check_val({nm, ".line_tick"},  int'(lt), int'(elt));
        check_val({nm, ".frame_tick"}, int'(ft), int'(elt && ey == vt - 1));
    endtask

    task automatic step(input logic ra, input logic rb, input logic rc);
        @(negedge clk);
        rst_a = ra;
        rst_b = rb;
        rst_c = rc;
        #1;
        check_dut("a", rst_a ? 0 : na, 4, 640, 16, 96, 48, 480, 10, 2, 33,
                  a_pt, a_x, a_y, a_vo, a_hs, a_vs, a_lt, a_ft);
        check_dut("b", rst_b ? 0 : nb, 3, HD, HF, HS, HB, VD, VF, VS, VB,
                  b_pt, b_x, b_y, b_vo, b_hs, b_vs, b_lt, b_ft);
        check_dut("c", rst_c ? 0 : nc, 1, HD, HF, HS, HB, VD, VF, VS, VB,
                  c_pt, c_x, c_y, c_vo, c_hs, c_vs, c_lt, c_ft);
        if (!rst_a && na >= 1 && na <= 3200) begin
            a_hs_lo += int'(a_pt && !a_hs);
            a_lines += int'(a_lt);
            a_blank += int'(a_pt && !a_vo);
        end
        if (!rst_b && nb >= 1 && nb <= HT * VT * 3) begin
            b_von     += int'(b_vo);
            b_frames  += int'(b_ft);
            b_vs_lo   += int'(b_pt && !b_vs);
            b_row_hit += int'(b_pt && b_x == 10'd0 && b_y == 10'(VD + 1));
        end
        if (!rst_c && nc >= 1 && nc <= HT * VT) begin
            c_frames += int'(c_ft);
            c_ticks  += int'(c_pt);
        end
    endtask

    initial begin
        logic [2:0] mask;
        int         run_len, hold;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4000 && bad < 40; i++) step(1'b0, 1'b0, 1'b0);

        check_val("a.hsync_low_pixels", a_hs_lo, 96);
        check_val("a.line_ticks",       a_lines, 1);
        check_val("a.blank_pixels",     a_blank, 160);
        check_val("b.video_on_clks",    b_von,   HD * VD * 3);
        check_val("b.frame_ticks",      b_frames, 1);
        check_val("b.vsync_low_pixels", b_vs_lo, VS * HT);
        check_val("b.row_hit",          b_row_hit, 1);
        check_val("c.frame_ticks",      c_frames, 1);
        check_val("c.p_ticks",          c_ticks, HT * VT);

        for (int r = 0; r < 20 && bad < 40; r++) begin
            run_len = $urandom_range(200, 1500);
            for (int i = 0; i < run_len && bad < 40; i++) step(1'b0, 1'b0, 1'b0);
            mask = 3'($urandom_range(1, 7));
            hold = $urandom_range(1, 3);
            for (int i = 0; i < hold && bad < 40; i++) step(mask[0], mask[1], mask[2]);
        end
        for (int i = 0; i < 200 && bad < 40; i++) step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
